// File: rtl/keypad_scanner.sv
// keypad_scanner: matrix keypad scanner with scan-level debounce, press/release/multi-key events.
// Define KEYPAD_AUTOREPEAT_EN to re-issue key_valid every REPEAT_SCANS scans while a key is held.
module keypad_scanner #(
  parameter int N_COLS = 4,
  parameter int N_ROWS = 4,
  parameter int SETTLE_CYC = 4,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int REPEAT_SCANS = 32,
  localparam int CW = $clog2(N_COLS),
  localparam int RW = $clog2(N_ROWS)
) (
  input  logic              clk,
  input  logic              reset,
  output logic [N_COLS-1:0] cols,
  input  logic [N_ROWS-1:0] rows,
  output logic              key_valid,
  output logic              key_release,
  output logic [CW+RW-1:0]  key_code,
  output logic              key_held,
  output logic              multi_key
);
  localparam int DW = $clog2(SETTLE_CYC);
  localparam int BW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DW_LAST = DW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] C_LAST = CW'(N_COLS - 1);
  localparam logic [BW-1:0] DEB = BW'(DEBOUNCE_SCANS);
  // Scan result kinds share the FSM encoding: none/single/multi == IDLE/PRESSED/MULTI.
  typedef enum logic [1:0] {IDLE, PRESSED, MULTI} state_t;
  logic [N_ROWS-1:0] r1, r2;
  logic [DW-1:0] dw;
  logic [CW-1:0] col;
  logic [1:0] acc_n, acc_sum;
  logic [CW+RW-1:0] acc_code, code_n, prev_code, accepted_code;
  logic [RW-1:0] first_row;
  state_t res, prev_kind, acc_kind, state;
  logic [BW-1:0] stab, stab_n;
  logic same_prev, same_acc, upd, rep_fire;
  always_comb begin
    acc_sum = acc_n;
    first_row = '0;
    for (int i = N_ROWS - 1; i >= 0; i--)
      if (r2[i]) first_row = RW'(i);
    for (int i = 0; i < N_ROWS; i++)
      if (r2[i] && acc_sum != 2'd2) acc_sum = acc_sum + 2'd1;
    code_n = (acc_n == 2'd0 && |r2) ? {col, first_row} : acc_code;
    res = state_t'(acc_sum);
    same_prev = res == prev_kind && (res != PRESSED || code_n == prev_code);
    same_acc = res == acc_kind && (res != PRESSED || code_n == accepted_code);
    stab_n = !same_prev ? BW'(1) : (stab == DEB ? stab : stab + 1'b1);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r1 <= '0;
      r2 <= '0;
      dw <= '0;
      col <= '0;
      cols <= N_COLS'(1);
      acc_n <= '0;
      acc_code <= '0;
      prev_kind <= IDLE;
      prev_code <= '0;
      stab <= '0;
      acc_kind <= IDLE;
      accepted_code <= '0;
      upd <= 1'b0;
    end else begin
      r1 <= rows;
      r2 <= r1;
      upd <= 1'b0;
      dw <= (dw == DW_LAST) ? '0 : dw + 1'b1;
      if (dw == DW_LAST) begin
        cols <= {cols[N_COLS-2:0], cols[N_COLS-1]};
        col <= (col == C_LAST) ? '0 : col + 1'b1;
        acc_n <= (col == C_LAST) ? 2'd0 : acc_sum;
        acc_code <= (col == C_LAST) ? '0 : code_n;
        if (col == C_LAST) begin
          prev_kind <= res;
          prev_code <= code_n;
          stab <= stab_n;
          if (stab_n == DEB && !same_acc) begin
            upd <= 1'b1;
            acc_kind <= res;
            accepted_code <= code_n;
          end
        end
      end
    end
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPW = $clog2(REPEAT_SCANS + 1);
  localparam logic [RPW-1:0] REP_LAST = RPW'(REPEAT_SCANS - 1);
  logic [RPW-1:0] rep;
  logic scan_end;
  assign rep_fire = scan_end && !upd && state == PRESSED && rep == REP_LAST;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rep <= '0;
      scan_end <= 1'b0;
    end else begin
      scan_end <= dw == DW_LAST && col == C_LAST;
      if (upd || state != PRESSED) rep <= '0;
      else if (scan_end) rep <= (rep == REP_LAST) ? '0 : rep + 1'b1;
    end
`else
  assign rep_fire = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      key_valid <= 1'b0;
      key_release <= 1'b0;
      key_code <= '0;
      key_held <= 1'b0;
      multi_key <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      key_release <= 1'b0;
      if (upd) begin
        state <= acc_kind;
        multi_key <= acc_kind == MULTI;
        if (acc_kind == IDLE) begin
          key_release <= key_held;
          key_held <= 1'b0;
        end else if (acc_kind == PRESSED && !(key_held && accepted_code == key_code)) begin
          key_release <= key_held;
          key_valid <= 1'b1;
          key_code <= accepted_code;
          key_held <= 1'b1;
        end
      end else if (rep_fire) key_valid <= 1'b1;
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of scan timing, debounce, press/release and multi-key events.
module tb_keypad_scanner;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] cols, rows, key_code;
  logic key_valid, key_release, key_held, multi_key;
  logic [3:0][3:0] keys = '0;
  int cyc = 0;
  int nvalid = 0;
  int nrel = 0;
  int last_valid_cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int v0, r0;
  keypad_scanner #(.REPEAT_SCANS(2)) dut (
    .clk(clk), .reset(reset), .cols(cols), .rows(rows), .key_valid(key_valid),
    .key_release(key_release), .key_code(key_code), .key_held(key_held), .multi_key(multi_key)
  );
  always #5 clk = ~clk;
  always_comb begin
    rows = '0;
    for (int c = 0; c < 4; c++)
      if (cols[c]) rows = rows | keys[c];
  end
  always @(posedge clk or posedge reset) cyc <= reset ? 0 : cyc + 1;
  always @(negedge clk) begin
    if (key_valid) begin
      nvalid++;
      last_valid_cyc = cyc;
    end
    if (key_release) nrel++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_cyc(input int k);
    while (cyc < k) @(negedge clk);
  endtask
  // Async reset between edges; outputs are checked before any clock edge arrives.
  task automatic pulse_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_cols", cols, 4'b0001);
    chk("rst_valid", key_valid, 0);
    chk("rst_release", key_release, 0);
    chk("rst_code", key_code, 0);
    chk("rst_held", key_held, 0);
    chk("rst_multi", multi_key, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    pulse_reset();
    wait_cyc(3);  chk("cols_c3", cols, 4'b0001);
    wait_cyc(4);  chk("cols_c4", cols, 4'b0010);
    wait_cyc(8);  chk("cols_c8", cols, 4'b0100);
    wait_cyc(12); chk("cols_c12", cols, 4'b1000);
    wait_cyc(16); chk("cols_c16", cols, 4'b0001);
    keys[1] = 4'b0100;
    pulse_reset();
    v0 = nvalid;
    wait_cyc(60);
    chk("press_cnt", nvalid - v0, 1);
    chk("press_cyc", last_valid_cyc, 49);
    chk("press_code", key_code, 4'b0110);
    chk("press_held", key_held, 1);
    chk("press_multi", multi_key, 0);
    wait_cyc(150);
    chk("hold_pulses", nvalid - v0, AR ? 4 : 1);
    r0 = nrel;
    keys = '0;
    wait_cyc(230);
    chk("rel_cnt", nrel - r0, 1);
    chk("rel_held", key_held, 0);
    chk("rel_code", key_code, 4'b0110);
    v0 = nvalid;
    for (int s = 0; s < 6; s++) begin
      wait_cyc(240 + 16 * s);
      keys[2] = (s % 2 == 0) ? 4'b0001 : 4'b0000;
    end
    wait_cyc(336);
    keys = '0;
    wait_cyc(400);
    chk("bounce_valid", nvalid - v0, 0);
    chk("bounce_held", key_held, 0);
    v0 = nvalid;
    r0 = nrel;
    keys[0] = 4'b0001;
    keys[3] = 4'b0010;
    wait_cyc(480);
    chk("multi_flag", multi_key, 1);
    chk("multi_valid", nvalid - v0, 0);
    chk("multi_held", key_held, 0);
    keys[0] = 4'b0000;
    wait_cyc(560);
    chk("single_multi", multi_key, 0);
    chk("single_valid", (nvalid - v0 != 0) && (AR || nvalid - v0 == 1), 1);
    chk("single_code", key_code, 4'b1101);
    chk("single_held", key_held, 1);
    chk("single_rel", nrel - r0, 0);
    keys = '0;
    wait_cyc(640);
    chk("single_off_rel", nrel - r0, 1);
    chk("single_off_held", key_held, 0);
    keys[1] = 4'b0100;
    wait_cyc(720);
    chk("mid_held", key_held, 1);
    chk("mid_code", key_code, 4'b0110);
    pulse_reset();
    v0 = nvalid;
    wait_cyc(60);
    chk("re_press_cnt", nvalid - v0, 1);
    chk("re_press_cyc", last_valid_cyc, 49);
    chk("re_press_code", key_code, 4'b0110);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised matrix-keypad scanner. It drives one-hot column strobes, samples synchronised row lines and debounces over whole scans. It reports single-key press and release events, plus a multi-key flag, to the downstream input logic. It generalises the fixed 4x4 ring-counter scanner with configurable matrix size, column settle time, scan-level debouncing, release events and optional auto-repeat.

## Interface
Parameters:
- N_COLS, 4, number of driven columns (≥2)
- N_ROWS, 4, number of sensed rows (≥2)
- SETTLE_CYC, 4, clock cycles each column is driven (≥3)
- DEBOUNCE_SCANS, 3, consecutive identical full-scan results required to accept a change (≥1)
- REPEAT_SCANS, 32, auto-repeat interval in scans (used only with KEYPAD_AUTOREPEAT_EN)

Ports (CW = $clog2(N_COLS), RW = $clog2(N_ROWS)):
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- cols  out  N_COLS  one-hot column strobe, active-high
- rows  in  N_ROWS  row sense lines, asynchronous, active-high (pressed key on the driven column pulls its row high)
- key_valid  out  1  one-cycle pulse: new accepted key press (or auto-repeat)
- key_release  out  1  one-cycle pulse: accepted release of the held key
- key_code  out  CW+RW  {column index, row index} of the last accepted key
- key_held  out  1  level: exactly one key is accepted as held
- multi_key  out  1  level: accepted scan result has ≥2 keys pressed

## Operation
- rows pass through a 2-flop synchroniser before any use.
- Column sequencer:
  - A dwell counter counts 0..SETTLE_CYC-1.
  - cols shifts to the next column when the dwell counter wraps, and wraps from column N_COLS-1 to column 0.
  - Synchronised rows are sampled on dwell count SETTLE_CYC-1.
- Scan accumulator:
  - Per scan it counts pressed bits, saturating at 2.
  - It captures the code of the first pressed bit found, with the lowest column first, then the lowest row.
  - After the column N_COLS-1 sample it produces a result: NONE, SINGLE(code) or MULTI. It then clears.
- Debouncer:
  - A result equal to the previous scan's result (code compared only for SINGLE) increments a stable counter, saturating at DEBOUNCE_SCANS.
  - A differing result resets the counter to 1.
  - When the counter reaches DEBOUNCE_SCANS and the result differs from the accepted state, the accepted state updates once.
- Event FSM, states IDLE / PRESSED / MULTI, evaluated on accepted updates only:
  - IDLE→PRESSED(A): key_valid pulse, key_code=A, key_held=1.
  - PRESSED(A)→IDLE: key_release pulse, key_held=0, key_code keeps A.
  - PRESSED(A)→PRESSED(B), B≠A: key_release and key_valid pulse in the same cycle, key_code=B.
  - IDLE/PRESSED→MULTI: multi_key=1, no pulses, key_code and key_held frozen.
  - MULTI→PRESSED(B):
    - multi_key=0.
    - If key_held=1 and B equals key_code: no pulses.
    - Otherwise: key_release pulses (only if key_held was 1), key_valid pulses, key_code=B, key_held=1.
  - MULTI→IDLE: multi_key=0; key_release pulses if key_held was 1; key_held=0.

## Timing
- Reset values: cols = column 0 one-hot (…0001); dwell, accumulator and debounce state cleared; accepted state IDLE; key_valid, key_release, key_code, key_held, multi_key all 0.
- Reset is asynchronous; outputs take reset values immediately. It may be applied mid-scan or mid-press. After release, scanning restarts at column 0, dwell 0.
- Scan period T = N_COLS·SETTLE_CYC cycles.
- A press stable from the start of a scan produces key_valid DEBOUNCE_SCANS·T + 1 cycles after that scan's first cycle. The +1 is for the registered FSM output.
- Pulses last exactly one cycle. Level outputs change in the same cycle as the corresponding pulse.

## Configuration
- KEYPAD_AUTOREPEAT_EN defined:
  - In PRESSED, a scan counter restarts on every key_valid.
  - After REPEAT_SCANS complete scans with no state change, key_valid pulses again with an unchanged key_code. This repeats every REPEAT_SCANS scans.
  - MULTI or IDLE stops and clears the scan counter.
- KEYPAD_AUTOREPEAT_EN undefined: no repeat logic; key_valid pulses only on FSM transitions listed above.

## Test plan
Defaults (4x4, SETTLE_CYC=4, T=16, DEBOUNCE_SCANS=3) unless stated:
- Reset → cols=0001 and all outputs 0. After release, cols=0010 at cycle 4, 0100 at 8, 1000 at 12, 0001 at 16.
- Key col1/row2 held from scan start → one key_valid at cycle 49, key_code=4'b0110, key_held=1. No further pulses without autorepeat.
- Bounce: key present in alternate scans for 6 scans → no key_valid, key_held stays 0.
- Release the held 0110 key → one key_release after 3 clean scans, key_held=0, key_code stays 0110.
- Keys col0/row0 and col3/row1 pressed together → multi_key=1, no key_valid. Release col0/row0 → multi_key=0, key_valid with key_code=4'b1101.
- Reset asserted mid-press → outputs cleared asynchronously. With the key still held after release, key_valid is asserted again at cycle 49. With KEYPAD_AUTOREPEAT_EN and REPEAT_SCANS=2, key_valid repeats every 32 cycles.
